// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle shared between the arbiter (slave) and
// the producers plus async FIFO write port (master).
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_overflow;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wdata;

    modport slave (
        input  req, req_data, fifo_full, fifo_overflow,
        output gnt, wr_en, wdata
    );

    modport master (
        output req, req_data, fifo_full, fifo_overflow,
        input  gnt, wr_en, wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// producers, with bounded bursts, stall on full and sticky overflow error.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.slave      bus,
    input  logic                  err_clr,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic                  err_overflow,
    output logic [15:0]           beat_total
);
    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]  MAX_BEATS = 4'(MAX_BURST);
    localparam logic [2:0]  LAST_RST  = 3'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state_q,      state_d;
    logic [2:0]  owner_q,      owner_d;
    logic [2:0]  last_owner_q, last_owner_d;
    logic [3:0]  beat_cnt_q,   beat_cnt_d;
    logic        err_q,        err_d;
    logic [15:0] total_q,      total_d;

    logic [IDX_W-1:0] owner_idx;
    logic [IDX_W-1:0] cand;
    logic [2:0]       pick;
    logic             pick_valid;
    logic             req_own;
    logic             accept_c;

    assign owner_idx = owner_q[IDX_W-1:0];
    assign req_own   = bus.req[owner_idx];
    assign accept_c  = (state_q == BURST) && req_own && !bus.fifo_full;

    // Round-robin scan starting just after the previous burst owner.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_owner_q) + k) % NUM_REQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick       = 3'(cand);
            end
        end
    end

    // Write-port drive: combinational so an accepted beat reaches the FIFO this cycle.
    always_comb begin
        bus.gnt   = '0;
        bus.wr_en = 1'b0;
        bus.wdata = '0;
        if (accept_c) begin
            bus.gnt   = NUM_REQ'(1) << owner_idx;
            bus.wr_en = 1'b1;
            bus.wdata = bus.req_data[DATA_WIDTH*owner_idx +: DATA_WIDTH];
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        total_d      = total_q;
        err_d        = bus.fifo_overflow | (err_q & ~err_clr);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (accept_c) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    total_d    = total_q + 16'd1;
                    if (beat_cnt_q + 4'd1 == MAX_BEATS) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (!req_own) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_RST;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            total_q      <= total_d;
        end
    end

    assign owner        = owner_q;
    assign busy         = (state_q == BURST);
    assign err_overflow = err_q;
    assign beat_total   = total_q;
endmodule
